fetch_queue_frontend: RTL

Single-edge instruction-fetch frontend for the pipelined MIPS core.
- Drives the instruction-memory address and predicts the next PC for every fetched word:
  - jumps are statically taken;
  - conditional branches use a 2-bit bimodal history table (BHT).
- Buffers fetched {pc, instr, prediction} in a parametrised FIFO toward decode.
- Accepts redirects and BHT training from execute.
- No branch delay slot.

---
 rtl/fetch_queue_frontend.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_queue_frontend.sv
// Instruction-fetch frontend: static jump / bimodal branch prediction feeding a
// small in-order queue toward decode, with redirect flush and BHT training.
module fetch_queue_frontend #(
    parameter int          DEPTH       = 4,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        iready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int K  = $clog2(BHT_ENTRIES);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } fq_entry_t;

    fq_entry_t     q [DEPTH];
    logic [1:0]    bht [BHT_ENTRIES];
    logic [31:0]   fpc;
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;

    logic [31:0] seq, br_target, ptarget;
    logic        ptaken, push, pop;
    logic [5:0]  op;
    logic [K-1:0] lk_idx, up_idx;

    assign iaddr     = fpc;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push      = iready & ~redirect & ((count < (PW+1)'(DEPTH)) | pop);

    assign out_pc          = q[head].pc;
    assign out_instr       = q[head].instr;
    assign out_pred_taken  = q[head].taken;
    assign out_pred_target = q[head].target;

    assign op        = idata[31:26];
    assign seq       = fpc + 32'd4;
    assign br_target = seq + {{14{idata[15]}}, idata[15:0], 2'b00};
    assign lk_idx    = fpc[K+1:2];
    assign up_idx    = upd_pc[K+1:2];

    always_comb begin
        ptaken  = 1'b0;
        ptarget = seq;
        case (op)
            6'd2, 6'd3: begin
                ptaken  = 1'b1;
                ptarget = {seq[31:28], idata[25:0], 2'b00};
            end
            6'd4, 6'd5, 6'd6, 6'd7: begin
                ptaken  = bht[lk_idx][1];
                ptarget = ptaken ? br_target : seq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fpc   <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            fpc   <= {redirect_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fpc  <= ptarget;
                tail <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (push) begin
            q[tail] <= '{pc: fpc, instr: idata, taken: ptaken, target: ptarget};
        end
    end

    // Training reads the current counter; a same-cycle lookup sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[up_idx] != 2'b11)
                bht[up_idx] <= bht[up_idx] + 2'b01;
            else if (!upd_taken && bht[up_idx] != 2'b00)
                bht[up_idx] <= bht[up_idx] - 2'b01;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{upd_pc[31:K+2], upd_pc[1:0], redirect_pc[1:0]};
endmodule
